// File: rtl/jedro1_top.sv
// jedro1: multi-cycle RV32 subset core (LUI/AUIPC/OP-IMM/OP/LW/SW, Zicsr on mscratch).
// Any unsupported encoding raises a sticky illegal flag and parks the core in HALT.

module jedro1_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i
);
  logic [31:0] regfile [0:31];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we_i && (rd_addr_i != 5'd0)) begin
      regfile[rd_addr_i] <= rd_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regfile[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regfile[rs2_addr_i];
endmodule

module jedro1_csr (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] csr_mscratch_r;

  always_ff @(posedge clk_i) begin
    if (rst_i)     csr_mscratch_r <= '0;
    else if (we_i) csr_mscratch_r <= wdata_i;
  end

  assign rdata_o = csr_mscratch_r;
endmodule

module jedro1_top #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_we_o,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  illegal_instr_o
);
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  illegal_q, illegal_d;
  logic [4:0]            ld_rd_q, ld_rd_d;

  logic [31:0] instr, imm_i, imm_s, imm_u, mem_addr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr, shamt;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data, rs2_data, alu_b, alu_res, csr_rdata, csr_src, csr_wdata, wb_data;
  logic        instr_ok, wb_en, is_load, is_store, csr_wr;
  logic        rf_we, csr_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  dmem_we;

  assign instr    = imem_rdata_i;
  assign opcode   = instr[6:0];
  assign rd_addr  = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign funct7   = instr[31:25];
  assign csr_addr = instr[31:20];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u    = {instr[31:12], 12'h000};
  assign mem_addr = rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign csr_src  = funct3[2] ? {27'd0, rs1_addr} : rs1_data;

  jedro1_regfile regfile_inst (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .we_i       (rf_we),
    .rd_addr_i  (rf_waddr),
    .rd_data_i  (rf_wdata)
  );

  jedro1_csr csr_inst (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (csr_we),
    .wdata_i (csr_wdata),
    .rdata_o (csr_rdata)
  );

  // funct7[5] selects SUB/SRA for OP and SRAI for OP-IMM (imm bit 10)
  always_comb begin
    alu_b = (opcode == OPC_OP) ? rs2_data : imm_i;
    shamt = alu_b[4:0];
    case (funct3)
      3'b000:  alu_res = (opcode == OPC_OP && funct7[5]) ? rs1_data - alu_b : rs1_data + alu_b;
      3'b001:  alu_res = rs1_data << shamt;
      3'b010:  alu_res = {31'd0, $signed(rs1_data) < $signed(alu_b)};
      3'b011:  alu_res = {31'd0, rs1_data < alu_b};
      3'b100:  alu_res = rs1_data ^ alu_b;
      3'b101:  alu_res = funct7[5] ? 32'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
      3'b110:  alu_res = rs1_data | alu_b;
      default: alu_res = rs1_data & alu_b;
    endcase
  end

  always_comb begin
    instr_ok  = 1'b1;
    wb_en     = 1'b0;
    wb_data   = alu_res;
    is_load   = 1'b0;
    is_store  = 1'b0;
    csr_wr    = 1'b0;
    csr_wdata = csr_rdata;
    case (opcode)
      OPC_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
      OPC_AUIPC: begin wb_en = 1'b1; wb_data = imm_u + 32'(pc_q); end
      OPC_OPIMM: begin
        wb_en = 1'b1;
        if (funct3 == 3'b001)      instr_ok = (funct7 == 7'h00);
        else if (funct3 == 3'b101) instr_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      OPC_OP: begin
        wb_en    = 1'b1;
        instr_ok = (funct7 == 7'h00) ||
                   ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_LOAD: begin
        is_load  = 1'b1;
        instr_ok = (funct3 == 3'b010) && (mem_addr[1:0] == 2'b00);
      end
      OPC_STORE: begin
        is_store = 1'b1;
        instr_ok = (funct3 == 3'b010) && (mem_addr[1:0] == 2'b00);
      end
      OPC_SYSTEM: begin
        wb_en    = 1'b1;
        wb_data  = csr_rdata;
        instr_ok = (funct3[1:0] != 2'b00) && (csr_addr == CSR_MSCRATCH);
        csr_wr   = (funct3[1:0] == 2'b01) || (rs1_addr != 5'd0);
        case (funct3[1:0])
          2'b01:   csr_wdata = csr_src;
          2'b10:   csr_wdata = csr_rdata | csr_src;
          2'b11:   csr_wdata = csr_rdata & ~csr_src;
          default: csr_wdata = csr_rdata;
        endcase
      end
      default: instr_ok = 1'b0;
    endcase
    if ((instr == '0) || (instr == '1)) instr_ok = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    ld_rd_d   = ld_rd_q;
    rf_we     = 1'b0;
    rf_waddr  = rd_addr;
    rf_wdata  = wb_data;
    csr_we    = 1'b0;
    dmem_we   = 4'b0000;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (!instr_ok) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (is_load) begin
          ld_rd_d = rd_addr;
          state_d = ST_MEM;
        end else begin
          rf_we   = wb_en;
          csr_we  = csr_wr;
          dmem_we = is_store ? 4'b1111 : 4'b0000;
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        rf_we    = 1'b1;
        rf_waddr = ld_rd_q;
        rf_wdata = dmem_rdata_i;
        pc_d     = pc_q + ADDR_WIDTH'(4);
        state_d  = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_FETCH;
      pc_q      <= BOOT_ADDR;
      illegal_q <= 1'b0;
      ld_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      ld_rd_q   <= ld_rd_d;
    end
  end

  // store strobe is masked during reset so an aborted SW never reaches memory
  assign dmem_we_o       = rst_i ? 4'b0000 : dmem_we;
  assign imem_addr_o     = pc_q;
  assign dmem_addr_o     = ADDR_WIDTH'(mem_addr);
  assign dmem_wdata_o    = rs2_data;
  assign illegal_instr_o = illegal_q;
endmodule

// File: tb/tb_jedro1_top.sv
// Self-checking bench for jedro1_top: directed programs plus random programs
// compared against an instruction-level reference model.

module tb_jedro1_top;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_we;
  logic        illegal;

  logic [31:0] imem   [0:255];
  logic [31:0] dmem   [0:63];
  logic [31:0] m_x    [0:31];
  logic [31:0] m_dmem [0:63];
  logic [31:0] m_csr, m_pc;
  int          st_cnt = 0;
  int          bad_we = 0;
  int          total  = 0;
  int          bad    = 0;

  always #5 clk = ~clk;

  jedro1_top #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BOOT_ADDR(32'h0)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .imem_addr_o     (imem_addr),
    .imem_rdata_i    (imem_rdata),
    .dmem_addr_o     (dmem_addr),
    .dmem_wdata_o    (dmem_wdata),
    .dmem_we_o       (dmem_we),
    .dmem_rdata_i    (dmem_rdata),
    .illegal_instr_o (illegal)
  );

  always @(posedge clk) begin
    imem_rdata <= imem[imem_addr[9:2]];
    dmem_rdata <= dmem[dmem_addr[7:2]];
    if (rst) begin
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
      st_cnt <= 0;
    end else begin
      if (dmem_we == 4'hF) begin
        dmem[dmem_addr[7:2]] <= dmem_wdata;
        st_cnt <= st_cnt + 1;
      end
      if (dmem_we != 4'h0 && dmem_we != 4'hF) bad_we <= bad_we + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xreg(input int i);
    return dut.regfile_inst.regfile[i];
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // Reference model: executes the program in imem at instruction granularity.
  task automatic iss_run(output int cycles, output int stores);
    logic [31:0] pc, ins, a, b, res, imm_i, imm_s, addr, src, nv;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    bit          ok, wr;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    for (int i = 0; i < 64; i++) m_dmem[i] = '0;
    m_csr = '0; pc = '0; cycles = 0; stores = 0;
    for (int step = 0; step < 300; step++) begin
      ins = imem[pc[9:2]];
      op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
      imm_i = {{20{ins[31]}}, ins[31:20]};
      imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      a = m_x[rs1]; ok = 1; wr = 1; res = '0;
      if (ins == 32'h0 || ins == 32'hFFFF_FFFF) ok = 0;
      else case (op)
        7'h37: res = {ins[31:12], 12'h0};
        7'h17: res = pc + {ins[31:12], 12'h0};
        7'h13, 7'h33: begin
          b = (op == 7'h33) ? m_x[rs2] : imm_i;
          case (f3)
            3'd0: if (op == 7'h33 && f7 == 7'h20) res = a - b;
                  else if (op == 7'h33 && f7 != 0) ok = 0;
                  else res = a + b;
            3'd1: if (f7 != 0) ok = 0; else res = a << b[4:0];
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: if (f7 == 7'h00) res = a >> b[4:0];
                  else if (f7 == 7'h20) res = $signed(a) >>> b[4:0];
                  else ok = 0;
            3'd6: res = a | b;
            default: res = a & b;
          endcase
          if (op == 7'h33 && f7 != 0 && f3 != 0 && f3 != 5) ok = 0;
        end
        7'h03: begin
          addr = a + imm_i;
          if (f3 != 3'd2 || addr[1:0] != 0) ok = 0; else res = m_dmem[addr[7:2]];
        end
        7'h23: begin
          addr = a + imm_s; wr = 0;
          if (f3 != 3'd2 || addr[1:0] != 0) ok = 0;
          else begin m_dmem[addr[7:2]] = m_x[rs2]; stores++; end
        end
        7'h73: begin
          if (ins[31:20] != 12'h340 || f3 == 0 || f3 == 4) ok = 0;
          else begin
            src = f3[2] ? {27'd0, rs1} : a;
            res = m_csr;
            nv  = (f3[1:0] == 1) ? src : (f3[1:0] == 2) ? (m_csr | src) : (m_csr & ~src);
            if (f3[1:0] == 1 || rs1 != 0) m_csr = nv;
          end
        end
        default: ok = 0;
      endcase
      if (!ok) begin cycles += 2; break; end
      if (wr && rd != 0) m_x[rd] = res;
      cycles += (op == 7'h03) ? 3 : 2;
      pc += 4;
    end
    m_pc = pc;
  endtask

  task automatic run_prog(input string name);
    int exp_cyc, exp_st, cyc;
    iss_run(exp_cyc, exp_st);
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0; cyc = 0;
    while (!illegal && cyc < 2000) begin @(negedge clk); cyc++; end
    check({name, ":cycles"}, cyc, exp_cyc);
    repeat (4) @(negedge clk);
    check({name, ":illegal"}, {31'd0, illegal}, 32'd1);
    check({name, ":pc"}, imem_addr, m_pc);
    check({name, ":stores"}, st_cnt, exp_st);
    check({name, ":we_idle"}, {28'd0, dmem_we}, 32'd0);
    for (int i = 1; i < 32; i++) check($sformatf("%s:x%0d", name, i), xreg(i), m_x[i]);
    check({name, ":mscratch"}, dut.csr_inst.csr_mscratch_r, m_csr);
    for (int i = 0; i < 64; i++) check($sformatf("%s:mem%0d", name, i), dmem[i], m_dmem[i]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [2:0]  csr_f3 [6];
    csr_f3 = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom);
    imm = 12'($urandom);
    case ($urandom_range(0, 6))
      0: begin
        if (f3 == 1) imm[11:5] = 7'h00;
        else if (f3 == 5) imm[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      1: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      2: return enc_u(20'($urandom), rd, 7'h37);
      3: return enc_u(20'($urandom), rd, 7'h17);
      4: return enc_i(12'h340, rs1, csr_f3[$urandom_range(0, 5)], rd, 7'h73);
      5: return enc_s(12'(4 * $urandom_range(0, 63)), rs2, 5'd0);
      default: return enc_i(12'(4 * $urandom_range(0, 63)), 5'd0, 3'd2, rd, 7'h03);
    endcase
  endfunction

  function automatic logic [31:0] rand_illegal();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0073;
      3: return enc_i(12'h341, 5'd1, 3'd1, 5'd5, 7'h73);
      4: return enc_s(12'd2, 5'd1, 5'd0);
      5: return enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3);
      6: return enc_i(12'd0, 5'd0, 3'd0, 5'd4, 7'h03);
      default: return enc_i({7'h20, 5'd3}, 5'd1, 3'd1, 5'd6, 7'h13);
    endcase
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  initial begin
    int n, cyc;
    clear_imem();
    repeat (2) @(negedge clk);
    check("rst:imem_addr", imem_addr, 32'h0);
    check("rst:illegal", {31'd0, illegal}, 32'd0);
    check("rst:we", {28'd0, dmem_we}, 32'd0);
    check("rst:mscratch", dut.csr_inst.csr_mscratch_r, 32'd0);
    for (int i = 1; i < 32; i++) check($sformatf("rst:x%0d", i), xreg(i), 32'd0);

    clear_imem();
    imem[0] = enc_i(12'd3, 5'd3, 3'd5, 5'd0, 7'h73);
    imem[1] = enc_i(12'h340, 5'd6, 3'd5, 5'd1, 7'h73);
    imem[0] = enc_i(12'h340, 5'd3, 3'd5, 5'd0, 7'h73);
    run_prog("t1");
    check("t1:x1_const", xreg(1), 32'd3);
    check("t1:csr_const", dut.csr_inst.csr_mscratch_r, 32'd6);

    clear_imem();
    imem[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13);
    imem[1] = enc_i(12'd1, 5'd1, 3'd0, 5'd2, 7'h13);
    imem[2] = enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd3);
    run_prog("t2");
    check("t2:x1_const", xreg(1), 32'hFFFF_FFFF);
    check("t2:x2_const", xreg(2), 32'h0);
    check("t2:x3_const", xreg(3), 32'h1);

    clear_imem();
    imem[0] = enc_u(20'h12345, 5'd1, 7'h37);
    imem[1] = enc_i(12'h678, 5'd1, 3'd0, 5'd1, 7'h13);
    imem[2] = enc_s(12'd8, 5'd1, 5'd0);
    imem[3] = enc_i(12'd8, 5'd0, 3'd2, 5'd2, 7'h03);
    run_prog("t3");
    check("t3:x2_const", xreg(2), 32'h1234_5678);
    check("t3:mem8_const", dmem[2], 32'h1234_5678);
    check("t3:stores_const", st_cnt, 32'd1);

    clear_imem();
    imem[0] = enc_i(12'h340, 5'd5, 3'd5, 5'd0, 7'h73);
    imem[1] = enc_i(12'h340, 5'd0, 3'd6, 5'd1, 7'h73);
    imem[2] = enc_i(12'h340, 5'd1, 3'd7, 5'd0, 7'h73);
    run_prog("t4");
    check("t4:x1_const", xreg(1), 32'd5);
    check("t4:csr_const", dut.csr_inst.csr_mscratch_r, 32'd4);

    clear_imem();
    imem[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13);
    imem[1] = enc_i(12'd9, 5'd0, 3'd0, 5'd2, 7'h13);
    run_prog("t5");
    check("t5:pc_const", imem_addr, 32'd8);

    for (int t = 0; t < 40; t++) begin
      clear_imem();
      n = $urandom_range(5, 30);
      for (int i = 0; i < n; i++) imem[i] = rand_instr();
      imem[n] = rand_illegal();
      run_prog($sformatf("rnd%0d", t));
    end

    clear_imem();
    imem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    imem[1] = enc_s(12'd0, 5'd1, 5'd0);
    imem[2] = enc_i(12'd0, 5'd0, 3'd2, 5'd2, 7'h03);
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    check("t6:x1_before", xreg(1), 32'd5);
    rst = 1;
    @(negedge clk);
    check("t6:x1", xreg(1), 32'd0);
    check("t6:x2", xreg(2), 32'd0);
    check("t6:pc", imem_addr, 32'd0);
    check("t6:illegal", {31'd0, illegal}, 32'd0);
    check("t6:we", {28'd0, dmem_we}, 32'd0);
    rst = 0;
    cyc = 0;
    while (!illegal && cyc < 200) begin @(negedge clk); cyc++; end
    check("t6:rerun_cycles", cyc, 32'd9);
    check("t6:rerun_x2", xreg(2), 32'd5);

    check("we_encoding", bad_we, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
